branch_predict_ctrl: RTL and testbench

// - Fetch-side branch prediction and PC-redirect controller for the 6-stage pipeline.
// - Looks up a direct-mapped BTB + 2-bit BHT with the IF PC and steers next-PC.
// - Compares the EX-stage branch resolution against the prediction carried down the pipe.
// - On mismatch: issues redirect + flush, then trains the tables one cycle later.

---
 rtl/bpu_pkg.sv | 29 ++
 rtl/bpu_table.sv | 85 ++++++++
 rtl/branch_predict_ctrl.sv | 138 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the fetch-side branch predictor: next-PC select
// encoding, 2-bit counter states and saturating arithmetic.
package bpu_pkg;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'b00,
    PCSEL_PRED   = 2'b01,
    PCSEL_EX_TGT = 2'b10,
    PCSEL_EX_SEQ = 2'b11
  } pc_sel_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CNT_ST) ? CNT_ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CNT_SNT) ? CNT_SNT : c - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped BTB + 2-bit BHT storage: one combinational read port for fetch
// lookup and one synchronous read-modify-write port that applies a training update.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CNT_INIT = CNT_WNT,
  localparam int        IDXW     = $clog2(ENTRIES),
  localparam int        TAGW     = XLEN - IDXW - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [XLEN-1:0] rd_target,
  output logic [1:0]      rd_cnt,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [TAGW-1:0] wr_tag,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_taken,
  input  logic            wr_is_jump
);

  logic            valid_q  [ENTRIES];
  logic [1:0]      cnt_q    [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];

  logic       wr_hit;
  logic       wr_valid_d;
  logic [1:0] wr_cnt_d;
  logic       wr_meta;

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // A taken resolution that misses (or finds a different tag) reallocates the
  // entry: branches start weakly taken, jumps strongly taken.
  always_comb begin
    wr_valid_d = valid_q[wr_idx];
    wr_cnt_d   = cnt_q[wr_idx];
    wr_meta    = 1'b0;
    if (wr_taken) begin
      wr_valid_d = 1'b1;
      wr_meta    = 1'b1;
      if (wr_is_jump) begin
        wr_cnt_d = CNT_ST;
      end else if (wr_hit) begin
        wr_cnt_d = sat_inc(cnt_q[wr_idx]);
      end else begin
        wr_cnt_d = CNT_WT;
      end
    end else if (wr_hit) begin
      wr_cnt_d = sat_dec(cnt_q[wr_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid_d;
      cnt_q[wr_idx]   <= wr_cnt_d;
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && wr_meta) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor and PC-redirect controller: BTB/BHT lookup on the
// IF PC, EX-stage mispredict detection, delayed table training and statistics.
module branch_predict_ctrl
  import bpu_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CNT_INIT = CNT_WNT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [1:0]      pc_sel,
  output logic            flush,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [IDXW-1:0] if_idx;
  logic [TAGW-1:0] if_tag;
  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  logic [XLEN-1:0] rd_target;
  logic [1:0]      rd_cnt;
  logic            rd_hit;

  logic    res;
  logic    mispred;
  pc_sel_e sel;

  logic            upd_valid_q;
  logic [IDXW-1:0] upd_idx_q;
  logic [TAGW-1:0] upd_tag_q;
  logic [XLEN-1:0] upd_target_q;
  logic            upd_taken_q;
  logic            upd_is_jump_q;

  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDXW+1:2];
  assign if_tag = if_pc[XLEN-1:IDXW+2];

  bpu_table #(
    .XLEN     (XLEN),
    .ENTRIES  (ENTRIES),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (if_idx),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_cnt     (rd_cnt),
    .wr_en      (upd_valid_q),
    .wr_idx     (upd_idx_q),
    .wr_tag     (upd_tag_q),
    .wr_target  (upd_target_q),
    .wr_taken   (upd_taken_q),
    .wr_is_jump (upd_is_jump_q)
  );

  assign rd_hit      = rd_valid && (rd_tag == if_tag);
  assign pred_taken  = rd_hit && rd_cnt[1];
  assign pred_target = rd_hit ? rd_target : '0;

  // A taken resolution is also wrong when it went to a different target.
  assign res     = ex_valid && (ex_is_branch || ex_is_jump);
  assign mispred = res && ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target != ex_pred_target)));
  assign flush   = mispred;

  always_comb begin
    sel = PCSEL_SEQ;
    if (mispred && ex_taken) begin
      sel = PCSEL_EX_TGT;
    end else if (mispred) begin
      sel = PCSEL_EX_SEQ;
    end else if (pred_taken) begin
      sel = PCSEL_PRED;
    end
  end
  assign pc_sel = sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
    end else begin
      upd_valid_q <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      upd_idx_q     <= ex_pc[IDXW+1:2];
      upd_tag_q     <= ex_pc[XLEN-1:IDXW+2];
      upd_target_q  <= ex_target;
      upd_taken_q   <= ex_taken;
      upd_is_jump_q <= ex_is_jump;
    end
  end

  always_comb begin
    stat_branches_d = res ? sat_inc32(stat_branches_q) : stat_branches_q;
    stat_mispred_d  = mispred ? sat_inc32(stat_mispred_q) : stat_mispred_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [1:0]  pc_sel;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int tests_run = 0;
  int tests_failed = 0;

  branch_predict_ctrl #(
    .XLEN    (32),
    .ENTRIES (64),
    .CNT_INIT(2'b01)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jump    (ex_is_jump),
    .ex_taken      (ex_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .pc_sel        (pc_sel),
    .flush         (flush),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic jmp, input logic tk,
                           input logic [31:0] tgt, input logic ppt, input logic [31:0] ppg);
    ex_valid       = 1'b1;
    ex_is_branch   = ~jmp;
    ex_is_jump     = jmp;
    ex_taken       = tk;
    ex_pc          = pc;
    ex_target      = tgt;
    ex_pred_taken  = ppt;
    ex_pred_target = ppg;
    #1;
  endtask

  task automatic idle;
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_is_jump     = 1'b0;
    ex_taken       = 1'b0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'h100;
    ex_pc = 32'h0;
    ex_target = 32'h0;
    idle();
    repeat (3) tick();
    reset = 1'b0;
    #1;

    // reset state
    check_eq("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("rst_pred_target", pred_target, 32'h0);
    check_eq("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
    check_eq("rst_flush", {31'd0, flush}, 32'd0);
    check_eq("rst_stat_br", stat_branches, 32'd0);
    check_eq("rst_stat_mp", stat_mispred, 32'd0);

    // first taken branch at 0x100 -> 0x200, predicted not-taken
    drive_res(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    check_eq("br1_flush", {31'd0, flush}, 32'd1);
    check_eq("br1_pc_sel", {30'd0, pc_sel}, 32'd2);
    tick();
    idle();
    check_eq("br1_write_latency", {31'd0, pred_taken}, 32'd0);
    check_eq("br1_stat_br", stat_branches, 32'd1);
    check_eq("br1_stat_mp", stat_mispred, 32'd1);
    tick();
    check_eq("br1_pred_taken", {31'd0, pred_taken}, 32'd1);
    check_eq("br1_pred_target", pred_target, 32'h200);
    check_eq("br1_pc_sel_pred", {30'd0, pc_sel}, 32'd1);

    // same branch resolves not-taken while predicted taken
    drive_res(32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h200);
    check_eq("nt_pc_sel", {30'd0, pc_sel}, 32'd3);
    check_eq("nt_flush", {31'd0, flush}, 32'd1);
    tick();
    idle();
    tick();
    check_eq("nt_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("nt_keeps_valid", pred_target, 32'h200);
    check_eq("nt_pc_sel_seq", {30'd0, pc_sel}, 32'd0);

    // four back-to-back taken updates: 01 -> 10 -> 11 -> 11 -> 11
    for (int k = 0; k < 4; k++) begin
      drive_res(32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200);
      check_eq($sformatf("b2b_flush_%0d", k), {31'd0, flush}, 32'd0);
      tick();
    end
    idle();
    tick();
    check_eq("sat_pred_taken", {31'd0, pred_taken}, 32'd1);
    drive_res(32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h200);
    tick();
    idle();
    tick();
    check_eq("cnt11_to_10", {31'd0, pred_taken}, 32'd1);
    drive_res(32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h200);
    tick();
    idle();
    tick();
    check_eq("cnt10_to_01", {31'd0, pred_taken}, 32'd0);
    check_eq("seq_stat_br", stat_branches, 32'd8);
    check_eq("seq_stat_mp", stat_mispred, 32'd4);

    // ex_valid=0 with live-looking ex_* fields must be ignored
    ex_valid = 1'b0; ex_is_branch = 1'b1; ex_taken = 1'b1;
    ex_pc = 32'h100; ex_target = 32'h999; ex_pred_taken = 1'b0;
    #1;
    check_eq("inv_flush", {31'd0, flush}, 32'd0);
    check_eq("inv_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    tick();
    check_eq("inv_no_update", {31'd0, pred_taken}, 32'd0);
    check_eq("inv_stat_br", stat_branches, 32'd8);
    check_eq("inv_stat_mp", stat_mispred, 32'd4);

    // JAL 0x300 -> 0x400 after a fresh reset
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst2_stat_br", stat_branches, 32'd0);
    if_pc = 32'h300;
    drive_res(32'h300, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    check_eq("jal_flush", {31'd0, flush}, 32'd1);
    tick();
    idle();
    tick();
    check_eq("jal_pred_taken", {31'd0, pred_taken}, 32'd1);
    check_eq("jal_pred_target", pred_target, 32'h400);
    drive_res(32'h300, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400);
    check_eq("jal_ok_flush", {31'd0, flush}, 32'd0);
    check_eq("jal_ok_pc_sel", {30'd0, pc_sel}, 32'd1);
    tick();
    idle();
    check_eq("jal_stat_br", stat_branches, 32'd2);
    check_eq("jal_stat_mp", stat_mispred, 32'd1);

    // aliasing: 0x100 and 0x200 share index 0 with ENTRIES=64
    if_pc = 32'h100;
    drive_res(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    check_eq("alias_pre_hit", {31'd0, pred_taken}, 32'd1);
    drive_res(32'h200, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    check_eq("alias_old_miss", {31'd0, pred_taken}, 32'd0);
    check_eq("alias_old_target", pred_target, 32'h0);
    if_pc = 32'h200;
    #1;
    check_eq("alias_new_taken", {31'd0, pred_taken}, 32'd1);
    check_eq("alias_new_target", pred_target, 32'h500);

    // reset during the write cycle cancels the pending update
    if_pc = 32'h100;
    drive_res(32'h100, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rstmid_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("rstmid_pred_target", pred_target, 32'h0);
    tick();
    check_eq("rstmid_still_empty", {31'd0, pred_taken}, 32'd0);
    check_eq("rstmid_stat_br", stat_branches, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
